turn_signal_seq: RTL and testbench



---
 rtl/turn_signal_seq_if.sv | 40 ++++
 rtl/turn_signal_seq.sv | 190 +++++++++++++++++++
 tb/tb_turn_signal_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/turn_signal_seq_if.sv
// rtl/turn_signal_seq_if.sv - stalk inputs and lamp-bank outputs of the turn-signal sequencer
//
// Purpose: bundles the request inputs and lamp/error outputs of turn_signal_seq.
// Signals:
//   left, right   turn requests, level-sensitive
//   hazard        hazard request (only acted on when the sequencer is built with HAZARD_EN)
//   l_signal      left lamp bank, LAMPS bits, bit 0 innermost
//   r_signal      right lamp bank, LAMPS bits, bit LAMPS-1 innermost
//   error         high while both directions are requested
// Modports:
//   master  drives the requests, observes the lamps (stalk side / bench)
//   slave   the sequencer itself
interface turn_signal_seq_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
  logic [LAMPS-1:0] l_signal;
  logic [LAMPS-1:0] r_signal;
  logic             error;

  modport master (
    output left,
    output right,
    output hazard,
    input  l_signal,
    input  r_signal,
    input  error
  );

  modport slave (
    input  left,
    input  right,
    input  hazard,
    output l_signal,
    output r_signal,
    output error
  );
endinterface

// File: rtl/turn_signal_seq.sv
// rtl/turn_signal_seq.sv - parametrised sequential turn-signal controller with thermometer sweep
//
// Purpose: drives two lamp banks with a sweep that lights one more lamp every
// DWELL clocks (step 0 is blank), restarting after all LAMPS are lit. Requesting
// both directions at once parks the block in ERROR with all lamps dark.
// Optional feature macro: HAZARD_EN -- when defined, hazard flashes both banks
// together (DWELL cycles on, DWELL cycles off) and overrides every other request.
// Parameters:
//   LAMPS  lamps per bank (>= 1)
//   DWELL  clock cycles each step is held (>= 1)
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    turn_signal_seq_if.slave: left/right/hazard in, l_signal/r_signal/error out
module turn_signal_seq #(
  parameter int LAMPS = 3,
  parameter int DWELL = 3
) (
  input logic              clock,
  input logic              reset,
  turn_signal_seq_if.slave bus
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
`ifdef HAZARD_EN
    S_HAZ_ON,
    S_HAZ_OFF,
`endif
    S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] step, step_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          boundary;
  logic          both;
  logic          haz_req;

  logic [LAMPS-1:0] l_out;
  logic [LAMPS-1:0] r_out;
  logic             err_out;

  // Last cycle of a dwell period; requests are only looked at here while sweeping.
  assign boundary = (cnt == CW'(DWELL - 1));
  assign both     = bus.left && bus.right;

`ifdef HAZARD_EN
  assign haz_req = bus.hazard;
`else
  // Hazard has no effect in this build; the input is deliberately left unused.
  logic unused_hazard;
  assign unused_hazard = bus.hazard;
  assign haz_req       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      step  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      cnt   <= cnt_n;
    end
  end

  // Next state. The dwell counter defaults to 0 so any state or step change
  // restarts the dwell; only a mid-dwell cycle advances it.
  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = '0;
    case (state)
      S_IDLE: begin
        step_n = '0;
        if (haz_req) begin
`ifdef HAZARD_EN
          state_n = S_HAZ_ON;
`endif
        end else if (both) begin
          state_n = S_ERROR;
        end else if (bus.left) begin
          state_n = S_LEFT;
        end else if (bus.right) begin
          state_n = S_RIGHT;
        end
      end

      S_LEFT, S_RIGHT: begin
        if (!boundary) begin
          cnt_n = cnt + 1'b1;
        end else begin
          step_n = '0;
          if (haz_req) begin
`ifdef HAZARD_EN
            state_n = S_HAZ_ON;
`endif
          end else if (both) begin
            state_n = S_ERROR;
          end else if ((state == S_LEFT) ? bus.left : bus.right) begin
            // Still requested: advance the sweep, blank step follows the full bank.
            step_n = (step == SW'(LAMPS)) ? '0 : step + 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      S_ERROR: begin
        step_n = '0;
        if (haz_req) begin
`ifdef HAZARD_EN
          state_n = S_HAZ_ON;
`endif
        end else if (!both) begin
          state_n = S_IDLE;
        end
      end

`ifdef HAZARD_EN
      S_HAZ_ON: begin
        step_n = '0;
        if (!boundary) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = S_HAZ_OFF;
        end
      end

      S_HAZ_OFF: begin
        step_n = '0;
        if (!boundary) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = bus.hazard ? S_HAZ_ON : S_IDLE;
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
        step_n  = '0;
      end
    endcase
  end

  // Moore output decode. Left bank fills from bit 0 upward, right bank fills
  // from bit LAMPS-1 downward, so both sweeps run outward from the centre.
  always_comb begin
    l_out   = '0;
    r_out   = '0;
    err_out = 1'b0;
    case (state)
      S_LEFT: begin
        for (int i = 0; i < LAMPS; i++) begin
          l_out[i] = (i < int'(step));
        end
      end
      S_RIGHT: begin
        for (int i = 0; i < LAMPS; i++) begin
          r_out[LAMPS-1-i] = (i < int'(step));
        end
      end
      S_ERROR: err_out = 1'b1;
`ifdef HAZARD_EN
      S_HAZ_ON: begin
        l_out = '1;
        r_out = '1;
      end
`endif
      default: begin
        l_out   = '0;
        r_out   = '0;
        err_out = 1'b0;
      end
    endcase
  end

  assign bus.l_signal = l_out;
  assign bus.r_signal = r_out;
  assign bus.error    = err_out;

endmodule

// File: tb/tb_turn_signal_seq.sv
// tb/tb_turn_signal_seq.sv - table-driven bench for turn_signal_seq (defaults, LAMPS=5/DWELL=2, DWELL=1)
module tb_turn_signal_seq;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  turn_signal_seq_if #(.LAMPS(3)) bus_a ();
  turn_signal_seq_if #(.LAMPS(5)) bus_b ();
  turn_signal_seq_if #(.LAMPS(3)) bus_c ();

  turn_signal_seq #(.LAMPS(3), .DWELL(3)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  turn_signal_seq #(.LAMPS(5), .DWELL(2)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  turn_signal_seq #(.LAMPS(3), .DWELL(1)) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

  typedef struct {
    int         d;
    bit         rst;
    bit         l;
    bit         r;
    bit         h;
    logic [7:0] el;
    logic [7:0] er;
    bit         ee;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  function automatic logic [7:0] lo(int n);
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic [7:0] hi(int n, int lamps);
    return 8'(((1 << n) - 1) << (lamps - n));
  endfunction

  function automatic void add(int d, bit rst, bit l, bit r, bit h,
                              logic [7:0] el, logic [7:0] er, bit ee, string name);
    vec_t v;
    v.d = d; v.rst = rst; v.l = l; v.r = r; v.h = h;
    v.el = el; v.er = er; v.ee = ee; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    #50000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: table did not complete within the wait limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Each row: inputs applied before an edge, outputs checked 1 time unit after it.
  initial begin
    logic [7:0] al, ar;
    logic       ae;

    bus_a.left = 1'b0; bus_a.right = 1'b0; bus_a.hazard = 1'b0;
    bus_b.left = 1'b0; bus_b.right = 1'b0; bus_b.hazard = 1'b0;
    bus_c.left = 1'b0; bus_c.right = 1'b0; bus_c.hazard = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus_a.l_signal !== '0 || bus_a.r_signal !== '0 || bus_a.error !== 1'b0 ||
        bus_b.l_signal !== '0 || bus_b.r_signal !== '0 || bus_b.error !== 1'b0 ||
        bus_c.l_signal !== '0 || bus_c.r_signal !== '0 || bus_c.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a l=%b r=%b e=%b, b l=%b r=%b e=%b, c l=%b r=%b e=%b",
               bus_a.l_signal, bus_a.r_signal, bus_a.error,
               bus_b.l_signal, bus_b.r_signal, bus_b.error,
               bus_c.l_signal, bus_c.r_signal, bus_c.error);
    end

    // reset state
    add(0, 1, 0, 0, 0, 0, 0, 0, "reset_a");
    add(0, 1, 1, 0, 0, 0, 0, 0, "reset_a_left_high");

    // left held 30 cycles: 000,001,011,111 each 3 cycles
    for (int k = 1; k <= 30; k++) add(0, 0, 1, 0, 0, lo(((k - 1) / 3) % 4), 0, 0, "a_left_sweep");
    add(0, 0, 0, 0, 0, 0, 0, 0, "a_left_release");
    add(0, 0, 0, 0, 0, 0, 0, 0, "a_idle");

    // right for 6 sampled edges then released at the step-2 boundary: never 110
    for (int k = 1; k <= 6; k++) add(0, 0, 0, 1, 0, 0, hi((k - 1) / 3, 3), 0, "a_right_short");
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 0, "a_right_release");

    // both requested in IDLE, then right dropped
    add(0, 0, 1, 1, 0, 0, 0, 1, "a_err_enter");
    add(0, 0, 1, 1, 0, 0, 0, 1, "a_err_hold");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_err_exit_idle");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_err_left_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_err_left_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_err_left_s0");
    add(0, 0, 1, 0, 0, 3'b001, 0, 0, "a_err_left_s1");
    // mid-step release only takes effect at the boundary
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "a_release_latency");
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "a_release_latency");
    add(0, 0, 0, 0, 0, 0, 0, 0, "a_release_idle");

    // reversal left -> right goes through one IDLE cycle
    for (int k = 1; k <= 6; k++) add(0, 0, 1, 0, 0, lo((k - 1) / 3), 0, 0, "a_rev_left");
    add(0, 0, 0, 1, 0, 0, 0, 0, "a_rev_idle");
    add(0, 0, 0, 1, 0, 0, 0, 0, "a_rev_right_s0");
    add(0, 0, 0, 1, 0, 0, 0, 0, "a_rev_right_s0");
    add(0, 0, 0, 1, 0, 0, 0, 0, "a_rev_right_s0");
    add(0, 0, 0, 1, 0, 0, 3'b100, 0, "a_rev_right_s1");
    add(0, 0, 0, 0, 0, 0, 3'b100, 0, "a_rev_release");
    add(0, 0, 0, 0, 0, 0, 3'b100, 0, "a_rev_release");
    add(0, 0, 0, 0, 0, 0, 0, 0, "a_rev_release_idle");

    // reset mid-sequence at LEFT s=2, left kept high
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 0, lo((k - 1) / 3), 0, 0, "a_pre_reset");
    add(0, 1, 1, 0, 0, 0, 0, 0, "a_mid_reset");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_restart_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_restart_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "a_restart_s0");
    add(0, 0, 1, 0, 0, 3'b001, 0, 0, "a_restart_s1");
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "a_restart_release");
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "a_restart_release");
    add(0, 0, 0, 0, 0, 0, 0, 0, "a_restart_idle");

`ifdef HAZARD_EN
    // hazard raised during LEFT s=1: flash at the boundary, IDLE after HAZ_OFF once dropped
    for (int k = 1; k <= 4; k++) add(0, 0, 1, 0, 0, lo((k - 1) / 3), 0, 0, "h_left");
    add(0, 0, 1, 0, 1, 3'b001, 0, 0, "h_wait_boundary");
    add(0, 0, 1, 0, 1, 3'b001, 0, 0, "h_wait_boundary");
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 1, 3'b111, 3'b111, 0, "h_on");
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 1, 0, 0, 0, "h_off");
    add(0, 0, 1, 0, 1, 3'b111, 3'b111, 0, "h_on2");
    add(0, 0, 0, 0, 0, 3'b111, 3'b111, 0, "h_on2");
    add(0, 0, 0, 0, 0, 3'b111, 3'b111, 0, "h_on2");
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, "h_off2");
    add(0, 0, 1, 0, 0, 0, 0, 0, "h_to_idle");
    add(0, 0, 1, 0, 0, 0, 0, 0, "h_left_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "h_left_s0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "h_left_s0");
    add(0, 0, 1, 0, 0, 3'b001, 0, 0, "h_left_s1");
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "h_release");
    add(0, 0, 0, 0, 0, 3'b001, 0, 0, "h_release");
    add(0, 0, 0, 0, 0, 0, 0, 0, "h_release_idle");
    // hazard outranks ERROR in IDLE
    add(0, 0, 1, 1, 1, 3'b111, 3'b111, 0, "h_over_error");
    add(0, 0, 0, 0, 0, 3'b111, 3'b111, 0, "h_over_error_on");
    add(0, 0, 0, 0, 0, 3'b111, 3'b111, 0, "h_over_error_on");
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 0, "h_over_error_off");
`else
    // hazard has no effect in the default build
    for (int k = 1; k <= 4; k++) add(0, 0, 1, 0, 1, lo((k - 1) / 3), 0, 0, "nh_left");
    add(0, 0, 0, 0, 1, 3'b001, 0, 0, "nh_release");
    add(0, 0, 0, 0, 1, 3'b001, 0, 0, "nh_release");
    add(0, 0, 0, 0, 1, 0, 0, 0, "nh_idle");
    add(0, 0, 0, 0, 1, 0, 0, 0, "nh_idle");
`endif

    // LAMPS=5, DWELL=2: six steps of two cycles, period 12
    for (int k = 1; k <= 24; k++) add(1, 0, 1, 0, 0, lo(((k - 1) / 2) % 6), 0, 0, "b_left_sweep");
    add(1, 0, 0, 0, 0, 0, 0, 0, "b_release");
    for (int k = 1; k <= 4; k++) add(1, 0, 0, 1, 0, 0, hi((k - 1) / 2, 5), 0, "b_right");
    add(1, 0, 0, 0, 0, 0, 0, 0, "b_right_release");

    // DWELL=1: every cycle is a boundary
    for (int k = 1; k <= 9; k++) add(2, 0, 1, 0, 0, lo((k - 1) % 4), 0, 0, "c_left_sweep");
    add(2, 0, 0, 0, 0, 0, 0, 0, "c_release");
    add(2, 0, 1, 1, 0, 0, 0, 1, "c_err");
    add(2, 0, 0, 1, 0, 0, 0, 0, "c_err_exit");
    add(2, 0, 0, 1, 0, 0, 0, 0, "c_right_s0");
    add(2, 0, 0, 1, 0, 0, 3'b100, 0, "c_right_s1");
    add(2, 0, 0, 0, 0, 0, 0, 0, "c_right_release");

    for (int i = 0; i < tbl.size(); i++) begin
      reset        = tbl[i].rst;
      bus_a.left   = (tbl[i].d == 0) && tbl[i].l;
      bus_a.right  = (tbl[i].d == 0) && tbl[i].r;
      bus_a.hazard = (tbl[i].d == 0) && tbl[i].h;
      bus_b.left   = (tbl[i].d == 1) && tbl[i].l;
      bus_b.right  = (tbl[i].d == 1) && tbl[i].r;
      bus_b.hazard = (tbl[i].d == 1) && tbl[i].h;
      bus_c.left   = (tbl[i].d == 2) && tbl[i].l;
      bus_c.right  = (tbl[i].d == 2) && tbl[i].r;
      bus_c.hazard = (tbl[i].d == 2) && tbl[i].h;
      @(posedge clock);
      #1;
      case (tbl[i].d)
        0:       begin al = 8'(bus_a.l_signal); ar = 8'(bus_a.r_signal); ae = bus_a.error; end
        1:       begin al = 8'(bus_b.l_signal); ar = 8'(bus_b.r_signal); ae = bus_b.error; end
        default: begin al = 8'(bus_c.l_signal); ar = 8'(bus_c.r_signal); ae = bus_c.error; end
      endcase
      checks++;
      if (al !== tbl[i].el || ar !== tbl[i].er || ae !== tbl[i].ee) begin
        errors++;
        $display("FAIL %s (row %0d): got l=%b r=%b err=%b, expected l=%b r=%b err=%b",
                 tbl[i].name, i, al, ar, ae, tbl[i].el, tbl[i].er, tbl[i].ee);
      end
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
